// File: rtl/axi_request_capture.sv
// axi_request_capture: AXI4-Lite slave that turns each register write into a
// 72-bit AXI-Stream request word {4'h0, strb, addr, data} held in a
// first-word-fall-through FIFO. A small read port reports the FIFO fill level
// (ARADDR[2] = 0) or the count of words sent (ARADDR[2] = 1).
// Build option: define REQ_CAPTURE_WSTRB_EN to forward WSTRB into TDATA[67:64];
// without it that field is forced to 4'hF.
//
// Write FSM
//   state   | meaning
//   W_IDLE  | collecting AW and W in any order; a latched channel drops its READY
//   W_PUSH  | both latched; waiting for a free FIFO entry to push the word
//   W_RESP  | word pushed; BVALID held until BREADY
// Read FSM
//   state   | meaning
//   R_IDLE  | ARREADY high, waiting for a read address
//   R_RESP  | RVALID/RDATA held until RREADY
module axi_request_capture #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  input  logic [2:0]  S_AXI_AWPROT,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  input  logic [2:0]  S_AXI_ARPROT,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [71:0] AXIS_TDATA,
  output logic        AXIS_TVALID,
  input  logic        AXIS_TREADY
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {W_IDLE, W_PUSH, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  wstate_t     wstate, wstate_n;
  rstate_t     rstate, rstate_n;
  logic        aw_done, aw_done_n, w_done, w_done_n;
  logic [31:0] addr_q, addr_n, data_q, data_n;
  logic [3:0]  strb_q, strb_n;
  logic        awready_q, awready_n, wready_q, wready_n, bvalid_q, bvalid_n;
  logic        arready_q, arready_n, rvalid_q, rvalid_n;
  logic [31:0] rdata_q, rdata_n;

  logic [71:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   sent_cnt;
  logic          full, empty, push, pop;
  logic [3:0]    strb_field;
  logic          unused_ok;

`ifdef REQ_CAPTURE_WSTRB_EN
  assign strb_field = strb_q;
  assign unused_ok  = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[31:3],
                        S_AXI_ARADDR[1:0]};
`else
  assign strb_field = 4'hF;
  assign unused_ok  = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[31:3],
                        S_AXI_ARADDR[1:0], strb_q};
`endif

  // Full is judged on start-of-cycle occupancy, so a same-cycle pop never frees room for a push.
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && AXIS_TREADY;

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign AXIS_TVALID   = !empty;
  assign AXIS_TDATA    = mem[rd_ptr];

  // Write FSM next state: latch AW/W independently, push when room, then hold B.
  always_comb begin
    wstate_n  = wstate;
    aw_done_n = aw_done;
    w_done_n  = w_done;
    addr_n    = addr_q;
    data_n    = data_q;
    strb_n    = strb_q;
    bvalid_n  = bvalid_q;
    push      = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (S_AXI_AWVALID && awready_q) begin
          aw_done_n = 1'b1;
          addr_n    = S_AXI_AWADDR;
        end
        if (S_AXI_WVALID && wready_q) begin
          w_done_n = 1'b1;
          data_n   = S_AXI_WDATA;
          strb_n   = S_AXI_WSTRB;
        end
        if (aw_done_n && w_done_n) wstate_n = W_PUSH;
      end
      W_PUSH: begin
        if (!full) begin
          push     = 1'b1;
          bvalid_n = 1'b1;
          wstate_n = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          bvalid_n  = 1'b0;
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          wstate_n  = W_IDLE;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
    awready_n = (wstate_n == W_IDLE) && !aw_done_n;
    wready_n  = (wstate_n == W_IDLE) && !w_done_n;
  end

  // Read FSM next state: sample the selected status word at the AR handshake.
  always_comb begin
    rstate_n = rstate;
    rvalid_n = rvalid_q;
    rdata_n  = rdata_q;
    case (rstate)
      R_IDLE: begin
        if (S_AXI_ARVALID && arready_q) begin
          rstate_n = R_RESP;
          rvalid_n = 1'b1;
          rdata_n  = S_AXI_ARADDR[2] ? sent_cnt : {{(32 - CW){1'b0}}, count};
        end
      end
      R_RESP: begin
        if (S_AXI_RREADY) begin
          rvalid_n = 1'b0;
          rstate_n = R_IDLE;
        end
      end
      default: rstate_n = R_IDLE;
    endcase
    arready_n = (rstate_n == R_IDLE);
  end

  // Control state registers; reset drops any half-latched or unresponded transaction.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate    <= W_IDLE;
      rstate    <= R_IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      wstate    <= wstate_n;
      rstate    <= rstate_n;
      aw_done   <= aw_done_n;
      w_done    <= w_done_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
      strb_q    <= strb_n;
      awready_q <= awready_n;
      wready_q  <= wready_n;
      bvalid_q  <= bvalid_n;
      arready_q <= arready_n;
      rvalid_q  <= rvalid_n;
      rdata_q   <= rdata_n;
    end
  end

  // FIFO pointers, occupancy and sent-word counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sent_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        sent_cnt <= sent_cnt + 32'd1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {4'h0, strb_field, addr_q, data_q};
  end

endmodule

// File: tb/tb_axi_request_capture.sv
// Self-checking bench for axi_request_capture: directed scenarios plus a
// randomized phase, checked against a queue-based model of the request stream.
module tb_axi_request_capture;
  localparam int DEPTH = 16;
`ifdef REQ_CAPTURE_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [71:0] AXIS_TDATA;
  logic        AXIS_TVALID;
  logic        AXIS_TREADY;

  always #5 clk = ~clk;

  axi_request_capture #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TREADY(AXIS_TREADY)
  );

  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_q[$];
  logic [31:0] sent_model = 32'd0;
  bit          rand_tready = 1'b0;

  function automatic logic [71:0] pack(input logic [31:0] a, input logic [31:0] d,
                                       input logic [3:0] s);
    return {4'h0, (STRB_EN ? s : 4'hF), a, d};
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream monitor: a transfer seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (resetn === 1'b1 && AXIS_TVALID === 1'b1 && AXIS_TREADY === 1'b1) begin
      chk("stream_word_expected", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) chk("stream_word", AXIS_TDATA, exp_q.pop_front());
      sent_model = sent_model + 32'd1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_tready) AXIS_TREADY = 1'($urandom_range(0, 1));
  endtask

  // lead > 0: W asserted lead cycles before AW; lead < 0: AW leads W.
  task automatic write_start(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead);
    int cyc, aw_at, w_at;
    bit aw_ok, w_ok, aw_hs, w_hs;
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    cyc = 0; aw_ok = 1'b0; w_ok = 1'b0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    exp_q.push_back(pack(a, d, s));
    S_AXI_AWVALID = (aw_at == 0);
    S_AXI_WVALID  = (w_at == 0);
    while (!(aw_ok && w_ok) && cyc < 40) begin
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      cyc++;
      if (aw_hs) begin aw_ok = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (w_hs)  begin w_ok  = 1'b1; S_AXI_WVALID  = 1'b0; end
      if (!aw_ok && cyc >= aw_at) S_AXI_AWVALID = 1'b1;
      if (!w_ok && cyc >= w_at)   S_AXI_WVALID  = 1'b1;
    end
    chk("aw_w_handshake", {70'd0, aw_ok, w_ok}, 72'h3);
  endtask

  task automatic wait_b(input int bmax, output int lat);
    lat = 0;
    while (S_AXI_BVALID !== 1'b1 && lat < bmax) begin
      tick();
      lat++;
    end
  endtask

  task automatic b_ack();
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_drop", 72'(S_AXI_BVALID), 72'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead);
    int lat;
    write_start(a, d, s, lead);
    wait_b(300, lat);
    chk("bvalid_seen", 72'(S_AXI_BVALID), 72'd1);
    chk("bresp_okay", 72'(S_AXI_BRESP), 72'd0);
    b_ack();
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] v);
    int cyc;
    bit hs;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    cyc = 0; hs = 1'b0;
    while (!hs && cyc < 20) begin
      hs = S_AXI_ARREADY;
      tick();
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    chk("ar_handshake", 72'(hs), 72'd1);
    chk("rvalid_next", 72'(S_AXI_RVALID), 72'd1);
    chk("rresp_okay", 72'(S_AXI_RRESP), 72'd0);
    v = S_AXI_RDATA;
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    chk("rvalid_drop", 72'(S_AXI_RVALID), 72'd0);
    chk("arready_back", 72'(S_AXI_ARREADY), 72'd1);
  endtask

  task automatic drain();
    int cyc;
    AXIS_TREADY = 1'b1;
    cyc = 0;
    while (AXIS_TVALID !== 1'b0 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("drained_tvalid", 72'(AXIS_TVALID), 72'd0);
    chk("drained_model", 72'(exp_q.size()), 72'd0);
  endtask

  initial begin
    logic [31:0] v, prev;
    int lat;
    resetn = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_AWPROT = 3'd0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_ARPROT = 3'd0; S_AXI_RREADY = 1'b0;
    AXIS_TREADY = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("reset_readies", 72'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 72'd0);
    chk("reset_valids", 72'({S_AXI_BVALID, S_AXI_RVALID, AXIS_TVALID}), 72'd0);
    chk("reset_resp_data", 72'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 72'd0);
    resetn = 1'b1;
    chk("readies_before_edge", 72'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 72'd0);
    tick();
    chk("readies_after_reset", 72'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 72'h7);

    // Single write, AW and W together
    AXIS_TREADY = 1'b1;
    write_start(32'h1000, 32'hDEADBEEF, 4'hF, 0);
    wait_b(10, lat);
    chk("t1_b_latency", 72'(lat), 72'd1);
    chk("t1_tvalid", 72'(AXIS_TVALID), 72'd1);
    chk("t1_tdata", AXIS_TDATA, 72'h0F_00001000_DEADBEEF);
    chk("t1_bresp", 72'(S_AXI_BRESP), 72'd0);
    b_ack();
    chk("t1_single_word", 72'(AXIS_TVALID), 72'd0);

    // W leads AW by three cycles
    write_start(32'h20, 32'h5, 4'hF, 3);
    chk("t2_wready_low_push", 72'({S_AXI_AWREADY, S_AXI_WREADY}), 72'd0);
    wait_b(10, lat);
    chk("t2_bvalid", 72'(S_AXI_BVALID), 72'd1);
    chk("t2_wready_low_resp", 72'(S_AXI_WREADY), 72'd0);
    b_ack();
    chk("t2_readies_back", 72'({S_AXI_AWREADY, S_AXI_WREADY}), 72'h3);
    tick();

    // Backpressure: fill the FIFO, 17th write withheld
    AXIS_TREADY = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_write(32'h100 + 32'(4 * i), $urandom, 4'hF, 0);
    write_start(32'h200, 32'h17171717, 4'hF, 0);
    wait_b(20, lat);
    chk("t3_b_withheld", 72'(S_AXI_BVALID), 72'd0);
    axi_read(32'h0, v);
    chk("t3_occupancy_full", 72'(v), 72'(DEPTH));
    AXIS_TREADY = 1'b1;
    wait_b(60, lat);
    chk("t3_b_after_pop", 72'(S_AXI_BVALID), 72'd1);
    b_ack();
    drain();

    // Status reads: occupancy and sent count
    AXIS_TREADY = 1'b0;
    for (int i = 0; i < 5; i++)
      do_write($urandom, $urandom, 4'hF, $urandom_range(0, 6) - 3);
    axi_read(32'h0, v);
    chk("t4_occupancy5", 72'(v), 72'd5);
    axi_read(32'h4, prev);
    chk("t4_sent_model", 72'(prev), 72'(sent_model));
    drain();
    axi_read(32'h4, v);
    chk("t4_sent_plus5", 72'(v), 72'(prev + 32'd5));
    axi_read(32'h0, v);
    chk("t4_occupancy0", 72'(v), 72'd0);

    // Strobe field
    AXIS_TREADY = 1'b0;
    do_write(32'h40, 32'h12345678, 4'h3, 0);
    chk("t5_strb_field", 72'(AXIS_TDATA[67:64]), STRB_EN ? 72'h3 : 72'hF);
    drain();

    // Reset while in RESP with three words queued
    AXIS_TREADY = 1'b0;
    do_write(32'h50, 32'hA, 4'hF, 0);
    do_write(32'h54, 32'hB, 4'hF, 0);
    write_start(32'h58, 32'hC, 4'hF, 0);
    wait_b(10, lat);
    chk("t6_in_resp", 72'({S_AXI_BVALID, AXIS_TVALID}), 72'h3);
    resetn = 1'b0;
    exp_q.delete();
    sent_model = 32'd0;
    tick();
    chk("t6_flushed", 72'({S_AXI_BVALID, AXIS_TVALID}), 72'd0);
    chk("t6_readies_reset", 72'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 72'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("t6_bvalid_dropped", 72'(S_AXI_BVALID), 72'd0);
    axi_read(32'h0, v);
    chk("t6_occupancy0", 72'(v), 72'd0);
    axi_read(32'h4, v);
    chk("t6_sent0", 72'(v), 72'd0);
    AXIS_TREADY = 1'b1;
    do_write(32'hABC0, 32'hCAFEF00D, 4'h9, 0);
    drain();
    axi_read(32'h4, v);
    chk("t6_sent1", 72'(v), 72'd1);

    // Randomized traffic against the queue model
    rand_tready = 1'b1;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        rand_tready = 1'b0;
        AXIS_TREADY = 1'b0;
        v = $urandom;
        axi_read(v, prev);
        chk("rand_read", 72'(prev), v[2] ? 72'(sent_model) : 72'(exp_q.size()));
        rand_tready = 1'b1;
      end else begin
        do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 6) - 3);
      end
    end
    rand_tready = 1'b0;
    drain();
    axi_read(32'h4, v);
    chk("final_sent", 72'(v), 72'(sent_model));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
